instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the single-cycle MIPS decode/control path. Holds the PC and issues one

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_perf_cnt.sv | 23 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding, reset PC default
// and a word-alignment helper used by the fetch stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Force an address onto a word boundary; the low two bits are dropped silently.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: retired fetches and stalled HOLD cycles.
// Both are 32-bit free-running and wrap to zero.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        consume,
  input  logic        stall,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
);

  // Count consumes and backpressured HOLD cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (consume) fetch_count  <= fetch_count + 32'd1;
      if (stall)   stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: IDLE -> REQ -> WAIT -> HOLD -> REQ ...
// One imem read outstanding at most. Valid/ready: a transfer happens on a rising
// edge where both valid and ready are high; the source keeps valid and payload
// stable until that edge. The rsp channel has no ready: a rsp_valid pulse is only
// captured in WAIT and ignored in every other state.
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_count/stall_cycles.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instrn_valid,
  input  logic        instrn_ready,
  output logic [31:0] instrn,
  output logic [5:0]  instrn_opcode,
  output logic [31:0] address_plus_4,
  input  logic [31:0] ctrl_in_address,
  output logic [1:0]  state_dbg,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles,
`endif
  output logic        busy_dbg
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instrn_q;
  logic [31:0]  addr_p4_q;
  logic         req_fire;
  logic         rsp_capture;
  logic         consume;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and decoded handshake outputs.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    instrn_valid   = 1'b0;
    req_fire       = 1'b0;
    rsp_capture    = 1'b0;
    consume        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          req_fire = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_capture = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instrn_valid = 1'b1;
        if (instrn_ready) begin
          consume = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC and captured-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= word_align(RESET_PC);
      instrn_q  <= 32'd0;
      addr_p4_q <= 32'd0;
    end else begin
      if (rsp_capture) begin
        instrn_q  <= imem_rsp_data;
        addr_p4_q <= pc_q + 32'd4;
      end
      if (consume) pc_q <= word_align(ctrl_in_address);
    end
  end

  assign imem_req_addr  = pc_q;
  assign instrn         = instrn_q;
  assign instrn_opcode  = instrn_q[31:26];
  assign address_plus_4 = addr_p4_q;
  assign state_dbg      = state_q;
  assign busy_dbg       = req_fire | (state_q == ST_WAIT);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .consume      (consume),
    .stall        (instrn_valid & ~instrn_ready),
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, jump, backpressure,
// request stall with spurious response, PC+4 wrap and reset in WAIT.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instrn_valid;
  logic        instrn_ready;
  logic [31:0] instrn;
  logic [5:0]  instrn_opcode;
  logic [31:0] address_plus_4;
  logic [31:0] ctrl_in_address;
  logic [1:0]  state_dbg;
  logic        busy_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instrn_valid    (instrn_valid),
    .instrn_ready    (instrn_ready),
    .instrn          (instrn),
    .instrn_opcode   (instrn_opcode),
    .address_plus_4  (address_plus_4),
    .ctrl_in_address (ctrl_in_address),
    .state_dbg       (state_dbg),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count     (fetch_count),
    .stall_cycles    (stall_cycles),
`endif
    .busy_dbg        (busy_dbg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting in REQ: accept, respond next cycle, consume in HOLD.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data,
                           input logic [5:0] exp_op, input logic [31:0] exp_p4,
                           input logic [31:0] next_pc);
    check("req_state", {30'd0, state_dbg}, {30'd0, S_REQ});
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, exp_addr);
    check("req_instrn_valid", {31'd0, instrn_valid}, 32'd0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    check("hold_valid", {31'd0, instrn_valid}, 32'd1);
    check("hold_instrn", instrn, data);
    check("hold_opcode", {26'd0, instrn_opcode}, {26'd0, exp_op});
    check("hold_addr_p4", address_plus_4, exp_p4);
    instrn_ready    = 1'b1;
    ctrl_in_address = next_pc;
    step();
    instrn_ready    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'd0;
    instrn_ready    = 1'b0;
    ctrl_in_address = 32'd0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values while held.
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instrn_valid", {31'd0, instrn_valid}, 32'd0);
    check("rst_instrn", instrn, 32'd0);
    check("rst_addr_p4", address_plus_4, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    rst = 1'b0;
    imem_req_ready = 1'b1;
    // Still IDLE right after release, REQ one cycle later.
    check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    step();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);

    // Sequential lw fetches.
    fetch_one(32'h0, 32'h8C22_0004, 6'h23, 32'h4, 32'h4);
    fetch_one(32'h4, 32'h8C23_0008, 6'h23, 32'h8, 32'h8);

    // Jump with misaligned target: low bits dropped.
    fetch_one(32'h8, 32'h0800_0010, 6'h02, 32'hC, 32'h0000_0043);
    check("jump_addr", imem_req_addr, 32'h0000_0040);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_3", fetch_count, 32'd3);
    check("stall_0", stall_cycles, 32'd0);
`endif

    // Backpressure in HOLD for 5 cycles.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1043_0005;
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_instrn", instrn, 32'h1043_0005);
      check("bp_opcode", {26'd0, instrn_opcode}, 32'h04);
      check("bp_addr_p4", address_plus_4, 32'h44);
      check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("bp_valid", {31'd0, instrn_valid}, 32'd1);
      step();
    end
`ifdef FETCH_PERF_CNT_EN
    check("stall_5", stall_cycles, 32'd5);
`endif
    instrn_ready    = 1'b1;
    ctrl_in_address = 32'h44;
    step();
    instrn_ready    = 1'b0;
    check("bp_next_addr", imem_req_addr, 32'h44);

    // Request not accepted for 3 cycles; spurious rsp and ready-without-valid ignored.
    ctrl_in_address = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = (i == 1);
      imem_rsp_data  = 32'hDEAD_BEEF;
      instrn_ready   = (i == 2);
      step();
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h44);
      check("stall_state", {30'd0, state_dbg}, {30'd0, S_REQ});
      check("stall_instrn", instrn, 32'h1043_0005);
    end
    imem_rsp_valid = 1'b0;
    instrn_ready   = 1'b0;
    fetch_one(32'h44, 32'hAC22_0008, 6'h2B, 32'h48, 32'hFFFF_FFFC);

    // PC+4 wrap.
    fetch_one(32'hFFFF_FFFC, 32'h0000_0020, 6'h00, 32'h0, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_6", fetch_count, 32'd6);
`endif

    // Reset pulse while in WAIT.
    check("pre_rst_addr", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("pre_rst_state", {30'd0, state_dbg}, {30'd0, S_WAIT});
    rst = 1'b1;
    #1;
    check("mid_rst_instrn_valid", {31'd0, instrn_valid}, 32'd0);
    check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mid_rst_instrn", instrn, 32'd0);
    check("mid_rst_addr_p4", address_plus_4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fetch_count", fetch_count, 32'd0);
    check("mid_rst_stall", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    fetch_one(32'h0, 32'h8C22_0004, 6'h23, 32'h4, 32'h4);
    check("post_rst_addr", imem_req_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
